// File: rtl/morph_pkg.sv
// Shared constants for the morphology front end: FSM state encoding, mode codes and the
// default flush-row pixel value.
package morph_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [1:0] MODE_ERODE  = 2'd0;
    localparam logic [1:0] MODE_DILATE = 2'd1;
    localparam logic [1:0] MODE_BYPASS = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam logic [7:0] PAD_VAL_DEF = 8'h00;

    // The reserved code behaves as bypass downstream, so it is folded here once.
    function automatic logic [1:0] sanitize_mode(input logic [1:0] mode);
        return (mode == MODE_RSVD) ? MODE_BYPASS : mode;
    endfunction

endpackage

// File: rtl/morph_frame_ctrl_if.sv
// Pixel/config bundle between the threshold stage, the frame sequencer and the 3x3 window.
// drop_cnt exists only when MORPH_DROP_CNT_EN is defined.
interface morph_frame_ctrl_if #(
    parameter int COL_W = 11,
    parameter int ROW_W = 10
);
    logic             cfg_en;
    logic [1:0]       cfg_mode;
    logic             in_de;
    logic [7:0]       in_data;
    logic             win_de;
    logic [7:0]       win_data;
    logic [1:0]       mode_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             frame_busy;
    logic             frame_done;
    logic             frame_err;
`ifdef MORPH_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    modport master (
        output cfg_en, cfg_mode, in_de, in_data,
`ifdef MORPH_DROP_CNT_EN
        input  drop_cnt,
`endif
        input  win_de, win_data, mode_q, col_q, row_q, frame_busy, frame_done, frame_err
    );

    modport slave (
        input  cfg_en, cfg_mode, in_de, in_data,
`ifdef MORPH_DROP_CNT_EN
        output drop_cnt,
`endif
        output win_de, win_data, mode_q, col_q, row_q, frame_busy, frame_done, frame_err
    );

endinterface

// File: rtl/morph_pos_cnt.sv
// Column/row position counter; the row stops at U_ROW (the flush row) and never wraps past it.
module morph_pos_cnt #(
    parameter int U_COL = 1280,
    parameter int U_ROW = 720,
    parameter int COL_W = $clog2(U_COL),
    parameter int ROW_W = $clog2(U_ROW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             col_nxt_wrap_o,
    output logic             row_last_o,
    output logic             row_pad_o
);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(U_COL - 1);
    localparam logic [COL_W-1:0] COL_PEN = COL_W'(U_COL - 2);
    localparam logic [ROW_W-1:0] ROW_LST = ROW_W'(U_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_PAD = ROW_W'(U_ROW);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                if (row_q != ROW_PAD) row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Flag that the next increment lands on the last column of a row.
    assign col_nxt_wrap_o = (col_q == COL_PEN);
    assign row_last_o     = (row_q == ROW_LST);
    assign row_pad_o      = (row_q == ROW_PAD);
    assign col_o          = col_q;
    assign row_o          = row_q;

endmodule

// File: rtl/morph_frame_ctrl.sv
// Frame sequencer ahead of the 3x3 morphology window: forwards pixels, appends a flush row,
// waits for the pipeline to drain. MORPH_DROP_CNT_EN adds a saturating dropped-pixel count.
module morph_frame_ctrl
    import morph_pkg::*;
#(
    parameter int         U_COL     = 1280,
    parameter int         U_ROW     = 720,
    parameter int         DRAIN_CYC = 3,
    parameter logic [7:0] PAD_VAL   = PAD_VAL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    morph_frame_ctrl_if.slave bus
);
    localparam int COL_W = $clog2(U_COL);
    localparam int ROW_W = $clog2(U_ROW + 1);
    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic             win_de_q, win_de_d;
    logic [7:0]       win_data_q, win_data_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic             cnt_clr, cnt_inc, drop_hit;
    logic             col_nxt_wrap, row_last, row_pad;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    morph_pos_cnt #(
        .U_COL(U_COL), .U_ROW(U_ROW), .COL_W(COL_W), .ROW_W(ROW_W)
    ) u_pos (
        .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .inc_i(cnt_inc),
        .col_o(col), .row_o(row),
        .col_nxt_wrap_o(col_nxt_wrap), .row_last_o(row_last), .row_pad_o(row_pad)
    );

    // Counter holds the coordinate of the pixel currently on win_*, so the exit tests look
    // one position ahead of the pixel being accepted this cycle.
    always_comb begin
        state_d    = state_q;
        win_de_d   = 1'b0;
        win_data_d = win_data_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        drn_d      = drn_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        drop_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_de && bus.cfg_en) begin
                    win_de_d   = 1'b1;
                    win_data_d = bus.in_data;
                    mode_d     = sanitize_mode(bus.cfg_mode);
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    cnt_clr    = 1'b1;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.in_de) begin
                    win_de_d   = 1'b1;
                    win_data_d = bus.in_data;
                    cnt_inc    = 1'b1;
                    if (col_nxt_wrap && row_last) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                win_de_d   = 1'b1;
                win_data_d = PAD_VAL;
                cnt_inc    = 1'b1;
                drop_hit   = bus.in_de;
                if (col_nxt_wrap && row_pad) begin
                    drn_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drop_hit = bus.in_de;
                if (drn_q == DRN_LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (drop_hit) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            win_de_q   <= 1'b0;
            win_data_q <= 8'h00;
            mode_q     <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            drn_q      <= '0;
        end else begin
            state_q    <= state_d;
            win_de_q   <= win_de_d;
            win_data_q <= win_data_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            drn_q      <= drn_d;
        end
    end

`ifdef MORPH_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (state_q == ST_IDLE && bus.in_de && bus.cfg_en) drop_d = '0;
        else if (drop_hit && drop_q != 16'hFFFF)           drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign bus.drop_cnt = drop_q;
`endif

    assign bus.win_de     = win_de_q;
    assign bus.win_data   = win_data_q;
    assign bus.mode_q     = mode_q;
    assign bus.col_q      = col;
    assign bus.row_q      = row;
    assign bus.frame_busy = busy_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Scoreboard bench for morph_frame_ctrl: a frame-level model predicts every window pixel, pad
// and frame_done with its cycle; a negedge monitor pops and compares.
module tb_morph_frame_ctrl;

    localparam int U_COL     = 8;
    localparam int U_ROW     = 4;
    localparam int DRAIN_CYC = 3;
    localparam int N_PIX     = U_COL * U_ROW;
    localparam int PAD_EXP   = 0;

    typedef struct {
        bit isDone;
        int data;
        int col;
        int row;
        int mode;
        bit err;
        int drops;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nVec = 0;
    int   nErr = 0;
    exp_t q[$];
    exp_t e;

    bit mActive = 1'b0;
    int mPix, mMode, mDone, mDrops;
    bit mErr;

    morph_frame_ctrl_if #(.COL_W($clog2(U_COL)), .ROW_W($clog2(U_ROW + 1))) bus();

    morph_frame_ctrl #(
        .U_COL(U_COL), .U_ROW(U_ROW), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; the model works per frame: N_PIX accepted pixels, then U_COL pads,
    // then frame_done DRAIN_CYC cycles after the last pad. Any in_de in between is a drop.
    task automatic applyStimulus(input bit de, input int data, input bit en, input int mode);
        int k;
        @(negedge clk);
        bus.in_de    = de;
        bus.in_data  = 8'(data);
        bus.cfg_en   = en;
        bus.cfg_mode = 2'(mode);
        k = cyc;
        if (mActive && mPix < N_PIX) begin
            if (de) begin
                q.push_back('{1'b0, data & 255, mPix % U_COL, mPix / U_COL, mMode, 1'b0, 0, k + 1});
                mPix++;
                if (mPix == N_PIX) begin
                    for (int c = 0; c < U_COL; c++)
                        q.push_back('{1'b0, PAD_EXP, c, U_ROW, mMode, 1'b0, 0, k + 2 + c});
                    mDone = k + 1 + U_COL + DRAIN_CYC;
                end
            end
        end else if (mActive) begin
            if (de) begin
                mErr = 1'b1;
                if (mDrops < 65535) mDrops++;
            end
            if (k == mDone - 1) begin
                q.push_back('{1'b1, 0, 0, 0, mMode, mErr, mDrops, mDone});
                mActive = 1'b0;
            end
        end else if (de && en) begin
            mActive = 1'b1;
            mMode   = (mode == 3) ? 2 : mode;
            mErr    = 1'b0;
            mDrops  = 0;
            mPix    = 1;
            q.push_back('{1'b0, data & 255, 0, 0, mMode, 1'b0, 0, k + 1});
        end
    endtask

    task automatic sendPixels(input int n, input bit en, input int mode, input int gapPct,
                              input bit toggle, input int changeAt, input int newMode);
        int sent = 0;
        int curMode = mode;
        while (sent < n) begin
            if (!toggle && int'($urandom_range(99)) < gapPct) begin
                applyStimulus(1'b0, 0, en, curMode);
            end else begin
                applyStimulus(1'b1, int'($urandom_range(255)), en, curMode);
                sent++;
                if (sent == changeAt) curMode = newMode;
                if (toggle) applyStimulus(1'b0, 0, en, curMode);
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b1, 0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_win_de", bus.win_de, 0);
        checkOutput("rst_win_data", bus.win_data, 0);
        checkOutput("rst_mode_q", bus.mode_q, 0);
        checkOutput("rst_col_q", bus.col_q, 0);
        checkOutput("rst_row_q", bus.row_q, 0);
        checkOutput("rst_frame_busy", bus.frame_busy, 0);
        checkOutput("rst_frame_done", bus.frame_done, 0);
        checkOutput("rst_frame_err", bus.frame_err, 0);
`ifdef MORPH_DROP_CNT_EN
        checkOutput("rst_drop_cnt", bus.drop_cnt, 0);
`endif
    endtask

    task automatic resetDut();
        @(negedge clk);
        bus.in_de = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs();
        q.delete();
        mActive = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: anything the DUT presents must match the head of the queue at the predicted cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checkOutput("missing_output_cycle", cyc, q[0].cyc);
                e = q.pop_front();
            end
            if (bus.win_de) begin
                if (q.size() == 0 || q[0].isDone || q[0].cyc != cyc) begin
                    checkOutput("unexpected_win_de", bus.win_de, 0);
                end else begin
                    e = q.pop_front();
                    checkOutput("win_data", bus.win_data, e.data);
                    checkOutput("col_q", bus.col_q, e.col);
                    checkOutput("row_q", bus.row_q, e.row);
                    checkOutput("mode_q", bus.mode_q, e.mode);
                    checkOutput("busy_during_frame", bus.frame_busy, 1);
                end
            end
            if (bus.frame_done) begin
                if (q.size() == 0 || !q[0].isDone || q[0].cyc != cyc) begin
                    checkOutput("unexpected_frame_done", bus.frame_done, 0);
                end else begin
                    e = q.pop_front();
                    checkOutput("frame_err", bus.frame_err, e.err);
                    checkOutput("busy_at_done", bus.frame_busy, 0);
                    checkOutput("mode_at_done", bus.mode_q, e.mode);
`ifdef MORPH_DROP_CNT_EN
                    checkOutput("drop_cnt", bus.drop_cnt, e.drops);
`endif
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, queue size %0d", q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.cfg_en   = 1'b0;
        bus.cfg_mode = 2'd0;
        bus.in_de    = 1'b0;
        bus.in_data  = 8'h00;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs();
        rst_n = 1'b1;

        // Continuous frame, erode.
        sendPixels(N_PIX, 1'b1, 0, 0, 1'b0, 0, 0);
        idleCycles(20);
        // in_de toggling every cycle, dilate.
        sendPixels(N_PIX, 1'b1, 1, 0, 1'b1, 0, 0);
        idleCycles(20);
        // cfg_mode 0->1 at pixel 10 is ignored until the next frame.
        sendPixels(N_PIX, 1'b1, 0, 0, 1'b0, 10, 1);
        idleCycles(20);
        sendPixels(N_PIX, 1'b1, 1, 20, 1'b0, 0, 0);
        idleCycles(20);
        // Stray in_de during the flush row.
        sendPixels(N_PIX, 1'b1, 2, 0, 1'b0, 0, 0);
        applyStimulus(1'b0, 0, 1'b1, 2);
        applyStimulus(1'b1, 8'h5A, 1'b1, 2);
        idleCycles(20);
        // cfg_en low: nothing forwarded, then a normal frame in reserved mode.
        sendPixels(N_PIX, 1'b0, 0, 0, 1'b0, 0, 0);
        checkOutput("en0_busy", bus.frame_busy, 0);
        idleCycles(3);
        sendPixels(N_PIX, 1'b1, 3, 10, 1'b0, 0, 0);
        idleCycles(20);
        // Reset mid-frame, then a clean frame from (0,0).
        sendPixels(20, 1'b1, 1, 0, 1'b0, 0, 0);
        resetDut();
        sendPixels(N_PIX, 1'b1, 0, 0, 1'b0, 0, 0);
        idleCycles(20);
        // Randomised frames with random gaps, modes and stray pixels in flush/drain.
        for (int f = 0; f < 6; f++) begin
            sendPixels(N_PIX, 1'b1, int'($urandom_range(3)), int'($urandom_range(50)), 1'b0,
                       int'($urandom_range(40)), int'($urandom_range(3)));
            for (int s = 0; s < U_COL + DRAIN_CYC; s++)
                applyStimulus(int'($urandom_range(99)) < 30, int'($urandom_range(255)),
                              1'b1, int'($urandom_range(3)));
            idleCycles(5);
        end
        idleCycles(20);
        checkOutput("queue_drained", q.size(), 0);
        checkOutput("final_busy", bus.frame_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
